// File: rtl/multi_debouncer.sv
// Multi-channel push-button debouncer: per-channel two-flop synchroniser, stability
// counter and hold counter, producing a debounced level plus press/release/long-press strobes.
module multi_debouncer #(
    parameter int CHANNELS     = 4,
    parameter int CNT_WIDTH    = 17,
    parameter int STABLE_COUNT = 100000,
    parameter int HOLD_WIDTH   = 26,
    parameter int LONG_COUNT   = 50000000,
    parameter int ACTIVE_LOW   = 1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [CHANNELS-1:0] buttons,
    output logic [CHANNELS-1:0] level,
    output logic [CHANNELS-1:0] press,
    output logic [CHANNELS-1:0] release_pulse,
    output logic [CHANNELS-1:0] long_press
);

    localparam logic [CNT_WIDTH-1:0]  STABLE_LAST = CNT_WIDTH'(STABLE_COUNT - 1);
    localparam logic [HOLD_WIDTH-1:0] LONG_LAST   = HOLD_WIDTH'(LONG_COUNT - 1);
    localparam logic [HOLD_WIDTH-1:0] LONG_FULL   = HOLD_WIDTH'(LONG_COUNT);

    logic [CHANNELS-1:0] pressed_raw;
    assign pressed_raw = (ACTIVE_LOW != 0) ? ~buttons : buttons;

    // 'release' is a reserved word, so that strobe is exposed as release_pulse.
    for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
        logic                  sync_p0;
        logic                  sync_p1;
        logic [CNT_WIDTH-1:0]  cnt;
        logic [HOLD_WIDTH-1:0] hold;
        logic                  level_q;
        logic                  press_q;
        logic                  release_q;
        logic                  long_q;
        logic                  accept;
        logic                  level_next;

        assign accept     = (sync_p1 != level_q) && (cnt == STABLE_LAST);
        assign level_next = accept ? sync_p1 : level_q;

        always_ff @(posedge clock) begin
            if (reset) begin
                sync_p0   <= 1'b0;
                sync_p1   <= 1'b0;
                cnt       <= '0;
                hold      <= '0;
                level_q   <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
                long_q    <= 1'b0;
            end else begin
                // Synchroniser stage boundary: sync_p1 is the metastability-safe sample.
                sync_p0 <= pressed_raw[ch];
                sync_p1 <= sync_p0;

                if ((sync_p1 == level_q) || accept)
                    cnt <= '0;
                else
                    cnt <= cnt + CNT_WIDTH'(1);

                level_q   <= level_next;
                press_q   <= level_next & ~level_q;
                release_q <= ~level_next & level_q;

                // A press being released on this edge never earns a long-press strobe.
                if (!level_q)
                    hold <= '0;
                else if (hold != LONG_FULL)
                    hold <= hold + HOLD_WIDTH'(1);
                long_q <= level_q && level_next && (hold == LONG_LAST);
            end
        end

        assign level[ch]         = level_q;
        assign press[ch]         = press_q;
        assign release_pulse[ch] = release_q;
        assign long_press[ch]    = long_q;
    end

endmodule

// File: tb/tb_multi_debouncer.sv
// Scoreboard bench for multi_debouncer: directed stimulus queues per-edge expected
// outputs; a negedge monitor matches them against the DUT outputs.
module tb_multi_debouncer;

    logic       clock = 1'b0;
    logic       reset;
    logic [1:0] buttons;
    logic [1:0] buttons_al;
    logic [1:0] level, press, rel, long_press;
    logic [1:0] al_level, al_press, al_rel, al_long;

    int edges  = 0;
    int checks = 0;
    int passed = 0;

    typedef struct {
        int         cyc;
        bit         inst;
        logic [1:0] lvl;
        logic [1:0] pr;
        logic [1:0] rl;
        logic [1:0] lp;
    } exp_t;

    exp_t sb[$];

    multi_debouncer #(
        .CHANNELS(2), .CNT_WIDTH(3), .STABLE_COUNT(4),
        .HOLD_WIDTH(4), .LONG_COUNT(10), .ACTIVE_LOW(0)
    ) dut (
        .clock(clock), .reset(reset), .buttons(buttons),
        .level(level), .press(press), .release_pulse(rel), .long_press(long_press)
    );

    multi_debouncer #(
        .CHANNELS(2), .CNT_WIDTH(3), .STABLE_COUNT(4),
        .HOLD_WIDTH(4), .LONG_COUNT(10), .ACTIVE_LOW(1)
    ) dut_al (
        .clock(clock), .reset(reset), .buttons(buttons_al),
        .level(al_level), .press(al_press), .release_pulse(al_rel), .long_press(al_long)
    );

    always #5 clock = ~clock;

    always @(posedge clock) edges <= edges + 1;

    // Monitor: every expectation tagged with the just-completed edge is compared now.
    always @(negedge clock) begin
        int   n;
        exp_t it;
        logic [7:0] got;
        logic [7:0] want;
        n = sb.size();
        for (int i = 0; i < n; i++) begin
            it = sb.pop_front();
            if (it.cyc == edges) begin
                got  = it.inst ? {al_level, al_press, al_rel, al_long}
                               : {level, press, rel, long_press};
                want = {it.lvl, it.pr, it.rl, it.lp};
                checks++;
                if (got === want)
                    passed++;
                else
                    $display("FAIL outputs inst%0d edge %0d: got level=%b press=%b release=%b long=%b, required level=%b press=%b release=%b long=%b",
                             it.inst, it.cyc, got[7:6], got[5:4], got[3:2], got[1:0],
                             want[7:6], want[5:4], want[3:2], want[1:0]);
            end else if (it.cyc < edges) begin
                checks++;
                $display("FAIL expired inst%0d edge %0d: monitor reached edge %0d, required a sample at edge %0d",
                         it.inst, it.cyc, edges, it.cyc);
            end else begin
                sb.push_back(it);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic expect_range(input int from, input int to, input bit inst,
                                input logic [1:0] l, input logic [1:0] p,
                                input logic [1:0] r, input logic [1:0] lp);
        exp_t it;
        for (int c = from; c <= to; c++) begin
            it.cyc  = c;
            it.inst = inst;
            it.lvl  = l;
            it.pr   = p;
            it.rl   = r;
            it.lp   = lp;
            sb.push_back(it);
        end
    endtask

    initial begin
        int e;
        int budget;
        reset      = 1'b1;
        buttons    = 2'b00;
        buttons_al = 2'b11;

        // Reset state on both instances.
        tick(1);
        e = edges;
        expect_range(e + 1, e + 2, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00);
        expect_range(e + 1, e + 2, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00);
        tick(2);
        reset = 1'b0;
        e = edges;
        expect_range(e + 1, e + 4, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00);
        expect_range(e + 1, e + 4, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00);
        tick(4);

        // Clean press on channel 0, short hold, release: no long press.
        e = edges;
        buttons[0] = 1'b1;
        expect_range(e + 1, e + 5, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00);
        expect_range(e + 6, e + 6, 1'b0, 2'b01, 2'b01, 2'b00, 2'b00);
        expect_range(e + 7, e + 9, 1'b0, 2'b01, 2'b00, 2'b00, 2'b00);
        tick(9);
        e = edges;
        buttons[0] = 1'b0;
        expect_range(e + 1, e + 5,  1'b0, 2'b01, 2'b00, 2'b00, 2'b00);
        expect_range(e + 6, e + 6,  1'b0, 2'b00, 2'b00, 2'b01, 2'b00);
        expect_range(e + 7, e + 12, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00);
        tick(12);

        // Bounce: high 3, low 1, high again; the glitch restarts the count.
        e = edges;
        buttons[0] = 1'b1;
        expect_range(e + 1,  e + 9,  1'b0, 2'b00, 2'b00, 2'b00, 2'b00);
        expect_range(e + 10, e + 10, 1'b0, 2'b01, 2'b01, 2'b00, 2'b00);
        expect_range(e + 11, e + 12, 1'b0, 2'b01, 2'b00, 2'b00, 2'b00);
        tick(3);
        buttons[0] = 1'b0;
        tick(1);
        buttons[0] = 1'b1;
        tick(8);
        e = edges;
        buttons[0] = 1'b0;
        expect_range(e + 1, e + 5, 1'b0, 2'b01, 2'b00, 2'b00, 2'b00);
        expect_range(e + 6, e + 6, 1'b0, 2'b00, 2'b00, 2'b01, 2'b00);
        expect_range(e + 7, e + 8, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00);
        tick(8);

        // Long press on channel 1 held ~100 cycles: exactly one long_press strobe.
        e = edges;
        buttons[1] = 1'b1;
        expect_range(e + 1,  e + 5,   1'b0, 2'b00, 2'b00, 2'b00, 2'b00);
        expect_range(e + 6,  e + 6,   1'b0, 2'b10, 2'b10, 2'b00, 2'b00);
        expect_range(e + 7,  e + 15,  1'b0, 2'b10, 2'b00, 2'b00, 2'b00);
        expect_range(e + 16, e + 16,  1'b0, 2'b10, 2'b00, 2'b00, 2'b10);
        expect_range(e + 17, e + 106, 1'b0, 2'b10, 2'b00, 2'b00, 2'b00);
        tick(106);
        e = edges;
        buttons[1] = 1'b0;
        expect_range(e + 1, e + 5, 1'b0, 2'b10, 2'b00, 2'b00, 2'b00);
        expect_range(e + 6, e + 6, 1'b0, 2'b00, 2'b00, 2'b10, 2'b00);
        expect_range(e + 7, e + 8, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00);
        tick(8);

        // Reset on the third disagreeing edge; held button is re-debounced afterwards.
        e = edges;
        buttons[0] = 1'b1;
        expect_range(e + 1, e + 4, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00);
        tick(4);
        reset = 1'b1;
        e = edges;
        expect_range(e + 1, e + 2, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00);
        expect_range(e + 1, e + 2, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00);
        tick(2);
        reset = 1'b0;
        e = edges;
        expect_range(e + 1, e + 5, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00);
        expect_range(e + 6, e + 6, 1'b0, 2'b01, 2'b01, 2'b00, 2'b00);
        expect_range(e + 7, e + 7, 1'b0, 2'b01, 2'b00, 2'b00, 2'b00);
        tick(7);
        e = edges;
        buttons[0] = 1'b0;
        expect_range(e + 1, e + 5, 1'b0, 2'b01, 2'b00, 2'b00, 2'b00);
        expect_range(e + 6, e + 6, 1'b0, 2'b00, 2'b00, 2'b01, 2'b00);
        expect_range(e + 7, e + 7, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00);
        tick(7);

        // Active-low instance: raw 0 is a press.
        e = edges;
        buttons_al[0] = 1'b0;
        expect_range(e + 1, e + 5, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00);
        expect_range(e + 6, e + 6, 1'b1, 2'b01, 2'b01, 2'b00, 2'b00);
        expect_range(e + 7, e + 7, 1'b1, 2'b01, 2'b00, 2'b00, 2'b00);
        tick(7);
        e = edges;
        buttons_al[0] = 1'b1;
        expect_range(e + 1, e + 5, 1'b1, 2'b01, 2'b00, 2'b00, 2'b00);
        expect_range(e + 6, e + 6, 1'b1, 2'b00, 2'b00, 2'b01, 2'b00);
        expect_range(e + 7, e + 7, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00);
        tick(7);

        budget = 50;
        while (sb.size() > 0 && budget > 0) begin
            tick(1);
            budget--;
        end
        while (sb.size() > 0) begin
            exp_t it;
            it = sb.pop_front();
            checks++;
            $display("FAIL unchecked inst%0d edge %0d: never sampled, required a sample", it.inst, it.cyc);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/multi_debouncer.md
MULTI_DEBOUNCER -- requirements
Module: multi_debouncer

Interface
REQ-001 The block SHALL have parameter CHANNELS, default 4, meaning the number of independent button channels (1..32).
REQ-002 The block SHALL have parameter CNT_WIDTH, default 17, meaning the width of each per-channel debounce counter.
REQ-003 The block SHALL have parameter STABLE_COUNT, default 100000, meaning the consecutive disagreeing cycles needed to accept a change; legal range 1..2^CNT_WIDTH-1.
REQ-004 The block SHALL have parameter HOLD_WIDTH, default 26, meaning the width of each per-channel hold counter.
REQ-005 The block SHALL have parameter LONG_COUNT, default 50000000, meaning the cycles of debounced-high before a long-press pulse; legal range 1..2^HOLD_WIDTH-1.
REQ-006 The block SHALL have parameter ACTIVE_LOW, default 1, meaning that when 1 each raw input is inverted before synchronisation (pressed = electrical 0).
REQ-007 The block SHALL have port clock, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-008 The block SHALL have port reset, input, 1 bit, synchronous active-high reset.
REQ-009 The block SHALL have port buttons, input, CHANNELS bits, raw asynchronous button levels.
REQ-010 The block SHALL have port level, output, CHANNELS bits, debounced pressed state (1 = pressed).
REQ-011 The block SHALL have port press, output, CHANNELS bits, one-cycle strobe on a debounced 0->1 transition.
REQ-012 The block SHALL have port release, output, CHANNELS bits, one-cycle strobe on a debounced 1->0 transition.
REQ-013 The block SHALL have port long_press, output, CHANNELS bits, one-cycle strobe when a press has been held LONG_COUNT cycles.

Function
REQ-014 Each channel SHALL be fully independent; no channel's state affects another.
REQ-015 Each raw bit SHALL be polarity-corrected per ACTIVE_LOW and then passed through a two-flop synchroniser; the second flop is sync_in.
REQ-016 Each channel SHALL hold a debounce counter: if sync_in == level, the counter becomes 0; otherwise it increments.
REQ-017 When sync_in != level and counter == STABLE_COUNT-1 at a rising edge, level SHALL take sync_in and the counter SHALL clear on that same edge.
REQ-018 Latency: a clean raw change first sampled at edge 1 SHALL appear on level after edge STABLE_COUNT+2.
REQ-019 Any single cycle of sync_in == level during counting SHALL restart the count from 0 (glitch rejection), for both press and release.
REQ-020 press (release) SHALL be registered and high for exactly the one cycle following the edge on which level rises (falls), aligned with the new level value.
REQ-021 Each channel SHALL hold a hold counter that clears whenever level is 0 and increments while level is 1, saturating at LONG_COUNT.
REQ-022 long_press SHALL pulse for one cycle when the hold counter transitions to LONG_COUNT; no further pulse SHALL occur until level has returned to 0 and risen again.
REQ-023 A release during a hold SHALL clear the hold counter, and no long_press SHALL occur for that press.
REQ-024 With STABLE_COUNT = 1, a change SHALL be accepted after a single disagreeing cycle (latency 3 edges); counters SHALL never wrap.
REQ-025 press and release SHALL never be high together on one channel; long_press SHALL never coincide with press on one channel.

Reset
REQ-026 While reset is high at a rising edge, the synchroniser flops, level, press, release, long_press and all counters SHALL become 0.
REQ-027 Reset asserted mid-debounce or mid-hold SHALL abandon the operation with no strobe; after release, a button still held SHALL be re-debounced and produce a fresh press.

Verification (CHANNELS=2, STABLE_COUNT=4, LONG_COUNT=10, ACTIVE_LOW=0)
REQ-028 Clean press: buttons[0] 0->1 first sampled at edge 1 and held -> level[0]=1 after edge 6; press[0]=1 for that cycle only; channel 1 unchanged.
REQ-029 Bounce: buttons[0] high 3 cycles, low 1, high again -> no press until 4 consecutive disagreeing sync cycles after the last bounce.
REQ-030 Long press: hold buttons[1] high -> press[1] strobe, then long_press[1] exactly 10 cycles after level[1] rises; a single pulse even if held 100 cycles.
REQ-031 Short press: release after 5 cycles of level=1 -> release strobe after 6 edges; no long_press; level returns to 0.
REQ-032 Reset mid-count: assert reset on the 3rd disagreeing cycle -> all outputs 0, no strobe; with the button held, press fires STABLE_COUNT+2 edges after reset deasserts.
REQ-033 ACTIVE_LOW=1: raw 1 -> level 0; raw 0 held -> level 1 after 6 edges with press strobe.
